lead_field_gen: RTL and testbench

//   Multi-cycle inverse of the CLO/CLZ unit. Given a count n and a fill bit, it

---
 rtl/lead_field_gen.sv | 121 ++++++++++++
 tb/tb_lead_field_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lead_field_gen.sv
// Builds a word whose leading-ones (or leading-zeros) count is exactly n.
// A log shifter advances one binary stage per clock under a start/done handshake.
module lead_field_gen #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_one_or_zero,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned K_W = $clog2(CNT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_n;
    logic             r_fill;
    logic [WIDTH-1:0] r_sh;
    logic [K_W-1:0]   r_k;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_n_sat;
    logic [CNT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_stage;
    logic [WIDTH-1:0] w_mark;
    logic [WIDTH-1:0] w_fixed;
    logic [WIDTH-1:0] w_final;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_n_sat  = (i_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : i_count;

    // Shift stage k: move sh right by 2^k, filling from the top with the fill bit.
    assign w_shamt = CNT_W'(1) << r_k;
    assign w_stage = WIDTH'({{WIDTH{r_fill}}, r_sh} >> w_shamt);

    // Terminator bit sits just below the leading field; vanishes when n == WIDTH.
    assign w_mark  = {1'b1, {(WIDTH-1){1'b0}}} >> r_n;
    assign w_fixed = r_fill ? (r_sh & ~w_mark) : (r_sh | w_mark);
    assign w_final = (r_n == CNT_W'(WIDTH)) ? {WIDTH{r_fill}} : w_fixed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_RUN;
            S_RUN:  if (r_k == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt != S_IDLE) w_busy_nxt = 1'b1;
        if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n      <= '0;
            r_fill   <= 1'b0;
            r_sh     <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_n    <= w_n_sat;
                r_fill <= i_one_or_zero;
                r_sh   <= i_data;
                r_k    <= K_W'(CNT_W - 1);
            end else if (r_state == S_RUN) begin
                if (r_n[r_k]) r_sh <= w_stage;
                if (r_k != '0) r_k <= K_W'(r_k - 1'b1);
            end else if (r_state == S_FIX) begin
                r_result <= w_final;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_lead_field_gen.sv
// Directed and random bench for lead_field_gen with a cycle-level reference model.
module tb_lead_field_gen;

    localparam int unsigned W     = 32;
    localparam int unsigned CW    = 6;
    localparam int unsigned LAT   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic [CW-1:0] i_count = '0;
    logic          i_fill = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_result;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    lead_field_gen #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (i_start),
        .i_data        (i_data),
        .i_count       (i_count),
        .i_one_or_zero (i_fill),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result)
    );

    always #5 clk = ~clk;

    // Reference: fill field of length n, then ~fill, then data >> n below it.
    function automatic logic [W-1:0] gen(input logic [W-1:0] d, input int c, input logic f);
        int n;
        logic [W-1:0] r;
        n = (c > W) ? W : c;
        r = (n >= W) ? '0 : (d >> n);
        for (int p = 0; p < W; p++) begin
            if (p >= W - n) r[p] = f;
            else if (p == W - 1 - n) r[p] = ~f;
        end
        return r;
    endfunction

    function automatic int lead_cnt(input logic [W-1:0] r, input logic f);
        int c;
        bit stop;
        c = 0;
        stop = 1'b0;
        for (int p = W - 1; p >= 0; p--) begin
            if (!stop && r[p] == f) c++;
            else stop = 1'b1;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: age counts cycles since the accepting edge.
    bit           m_active = 1'b0;
    int           m_age    = 0;
    logic [W-1:0] m_pending = '0;
    logic [W-1:0] m_result  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_result = '0;
        end else if (m_active) begin
            m_age++;
            if (m_age == LAT) m_result = m_pending;
            if (m_age == LAT + 1) m_active = 1'b0;
        end else if (i_start) begin
            m_active  = 1'b1;
            m_age     = 1;
            m_pending = gen(i_data, int'(i_count), i_fill);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   64'(o_busy),   64'(m_active));
            chk("done",   64'(o_done),   64'(m_active && m_age == LAT));
            chk("result", 64'(o_result), 64'(m_result));
        end
    end

    task automatic run_op(input logic [W-1:0] d, input logic [CW-1:0] c, input logic f,
                          input bit disturb, output logic [W-1:0] res);
        int lat;
        int n;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_data  = d;
        i_count = c;
        i_fill  = f;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (disturb && cyc >= 2 && cyc <= 7) begin
                i_start = 1'b1;
                i_count = CW'(1);
                i_data  = $urandom;
                i_fill  = ~f;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                lat = cyc;
                break;
            end
        end
        i_start = 1'b0;
        chk("latency", 64'(lat), 64'(LAT));
        res = o_result;
        n = (int'(c) > W) ? W : int'(c);
        chk("lead_count", 64'(lead_cnt(res, f)), 64'(n));
    endtask

    initial begin
        logic [W-1:0] res;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",   64'(o_busy),   64'd0);
        chk("rst_done",   64'(o_done),   64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        run_op(32'h0000FFFF, 6'd4,  1'b1, 1'b0, res);
        chk("t1_result", 64'(res), 64'h00000000_F0000FFF);
        run_op(32'h12345678, 6'd0,  1'b0, 1'b0, res);
        chk("t2_result", 64'(res), 64'h00000000_92345678);
        run_op(32'hDEADBEEF, 6'd31, 1'b0, 1'b0, res);
        chk("t3_n31_z",  64'(res), 64'h00000000_00000001);
        run_op(32'h13579BDF, 6'd31, 1'b1, 1'b0, res);
        chk("t3_n31_o",  64'(res), 64'h00000000_FFFFFFFE);
        run_op(32'hFFFFFFFF, 6'd32, 1'b0, 1'b0, res);
        chk("t3_n32_z",  64'(res), 64'h00000000_00000000);
        run_op(32'h00000000, 6'd40, 1'b1, 1'b0, res);
        chk("t3_n40_sat", 64'(res), 64'h00000000_FFFFFFFF);

        run_op(32'hA5A5A5A5, 6'd8, 1'b1, 1'b1, res);
        chk("t4_ignore_start", 64'(res), 64'h00000000_FF25A5A5);
        repeat (3) @(negedge clk);
        chk("t4_idle_after", 64'(o_busy), 64'd0);

        // Abort mid-RUN with a nonzero result still held from the previous op.
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_data  = 32'hCAFEF00D;
        i_count = 6'd20;
        i_fill  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",   64'(o_busy),   64'd0);
        chk("t5_done",   64'(o_done),   64'd0);
        chk("t5_result", 64'(o_result), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_op(32'h0F0F0F0F, 6'd2, 1'b0, 1'b0, res);
        chk("t5_after", 64'(res), 64'h00000000_23C3C3C3);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            logic [CW-1:0] c;
            logic f;
            d = $urandom;
            c = CW'($urandom_range(0, 63));
            f = 1'($urandom_range(0, 1));
            run_op(d, c, f, 1'b0, res);
        end

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
